// File: rtl/dbus_sram_responder_if.sv
// Data-bus request/response handshake bundle between a CPU Memory stage (master)
// and a memory responder (slave).
interface dbus_sram_responder_if;
   logic        req_valid;
   logic [31:0] req_addr;
   logic [2:0]  req_size;
   logic [3:0]  req_strobe;
   logic [31:0] req_data;
   logic        resp_addr_ok;
   logic        resp_data_ok;
   logic [31:0] resp_data;

   modport master (
      output req_valid, req_addr, req_size, req_strobe, req_data,
      input  resp_addr_ok, resp_data_ok, resp_data
   );

   modport slave (
      input  req_valid, req_addr, req_size, req_strobe, req_data,
      output resp_addr_ok, resp_data_ok, resp_data
   );
endinterface

// File: rtl/dbus_sram_responder.sv
// Word-addressed SRAM data-bus slave, one outstanding request, programmable latency.
// Optional per-request latency jitter from an 8-bit LFSR when DBUS_RANDOM_DELAY_EN is defined.
module dbus_sram_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   dbus_sram_responder_if.slave        dbus,
   output logic                        busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = 5;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [3:0]    strobe_q, strobe_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          addr_ok_q, addr_ok_d;
   logic          data_ok_q, data_ok_d;
   logic          busy_q, busy_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [31:0]   mem_q [DEPTH];
   logic          accept;
   logic [CW-1:0] load_count;
   logic          unused_req;

   assign unused_req = ^{dbus.req_size, dbus.req_addr[1:0], dbus.req_addr[31:AW+2]};
   assign accept     = addr_ok_q && dbus.req_valid;

`ifdef DBUS_RANDOM_DELAY_EN
   logic [7:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (accept)
         lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr_q <= 8'hA5;
      else       lfsr_q <= lfsr_d;
   end

   // Jitter uses the pre-shift LFSR value, adding 0..3 cycles.
   assign load_count = CW'(LATENCY - 1) + CW'(lfsr_q[1:0]);
`else
   assign load_count = CW'(LATENCY - 1);
`endif

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      idx_d    = idx_q;
      strobe_d = strobe_q;
      wdata_d  = wdata_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               idx_d    = dbus.req_addr[AW+1:2];
               strobe_d = dbus.req_strobe;
               wdata_d  = dbus.req_data;
               count_d  = load_count;
               state_d  = (load_count == '0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            count_d = count_q - CW'(1);
            if (count_q == CW'(1))
               state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Handshake outputs come straight from flops, decoded from the next state.
      addr_ok_d = (state_d == IDLE);
      data_ok_d = (state_d == RESP);
      busy_d    = (state_d != IDLE);
      rdata_d   = rdata_q;
      if (state_d == RESP)
         rdata_d = mem_q[idx_d];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         idx_q     <= '0;
         strobe_q  <= '0;
         wdata_q   <= '0;
         addr_ok_q <= 1'b0;
         data_ok_q <= 1'b0;
         busy_q    <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         idx_q     <= idx_d;
         strobe_q  <= strobe_d;
         wdata_q   <= wdata_d;
         addr_ok_q <= addr_ok_d;
         data_ok_q <= data_ok_d;
         busy_q    <= busy_d;
         rdata_q   <= rdata_d;
      end
   end

   // Write commits on the edge closing RESP, after the old word has been captured.
   always_ff @(posedge clk) begin
      if (state_q == RESP) begin
         for (int i = 0; i < 4; i++) begin
            if (strobe_q[i])
               mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   assign dbus.resp_addr_ok = addr_ok_q;
   assign dbus.resp_data_ok = data_ok_q;
   assign dbus.resp_data    = rdata_q;
   assign busy              = busy_q;
endmodule

// File: tb/tb_dbus_sram_responder.sv
// Self-checking bench for dbus_sram_responder: transaction-level reference model
// compared every cycle, plus directed literal checks and randomized traffic.
module tb_dbus_sram_responder;
   localparam int DEPTH   = 1024;
   localparam int LATENCY = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic busy;

   int compared   = 0;
   int mismatched = 0;

   dbus_sram_responder_if dbus ();

   dbus_sram_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clk   (clk),
      .reset (reset),
      .dbus  (dbus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   // Reference model: memory image with per-byte "known" flags, and the absolute
   // cycle number at which the single outstanding request must answer.
   logic [31:0] m_mem   [DEPTH];
   logic [3:0]  m_known [DEPTH];
   int          cyc     = 0;
   int          resp_at = -1;
   bit          live    = 1'b0;
   int          p_idx   = 0;
   logic [3:0]  p_strobe;
   logic [31:0] p_data;

   function automatic int word_of(input logic [31:0] a);
      return int'((a >> 2) % 32'(DEPTH));
   endfunction

   function automatic logic [31:0] lane_mask(input logic [3:0] k);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{k[i]}};
      return m;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic reportTimeout(input string name, input int waited);
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: timed out after %0d cycles, expected a response", name, waited);
   endtask

   // Model advance at each rising edge: close a due response (commit write) or accept.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_at = -1;
         live    = 1'b0;
      end else begin
         if (resp_at == cyc) begin
            for (int i = 0; i < 4; i++) begin
               if (p_strobe[i]) begin
                  m_mem[p_idx][8*i +: 8] = p_data[8*i +: 8];
                  m_known[p_idx][i]      = 1'b1;
               end
            end
            resp_at = -1;
         end else if (live && resp_at == -1 && dbus.req_valid) begin
            p_idx    = word_of(dbus.req_addr);
            p_strobe = dbus.req_strobe;
            p_data   = dbus.req_data;
            resp_at  = cyc + LATENCY;
         end
         live = 1'b1;
         cyc++;
      end
   end

   // Compare process: outputs checked mid-cycle against the model.
   always @(negedge clk) begin
      if (!reset) begin
         checkOutput("addr_ok", 32'(dbus.resp_addr_ok), 32'(live && resp_at == -1));
         checkOutput("data_ok", 32'(dbus.resp_data_ok), 32'(resp_at == cyc));
         if (resp_at != cyc)
            checkOutput("busy", 32'(busy), 32'(resp_at != -1));
         if (resp_at == cyc && m_known[p_idx] != 4'h0)
            checkOutput("resp_data", dbus.resp_data & lane_mask(m_known[p_idx]),
                        m_mem[p_idx] & lane_mask(m_known[p_idx]));
      end
   end

   // Present a request at a falling edge and hold it until the slave accepts it.
   task automatic applyStimulus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                                input int gap, output bit ok);
      int n = 0;
      @(negedge clk);
      dbus.req_valid  = 1'b1;
      dbus.req_addr   = a;
      dbus.req_strobe = s;
      dbus.req_data   = d;
      while (dbus.resp_addr_ok !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      ok = (n < 40);
      if (!ok) begin
         reportTimeout("accept", n);
         dbus.req_valid = 1'b0;
      end else begin
         @(posedge clk);
         if (gap > 0) begin
            @(negedge clk);
            dbus.req_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
         end
      end
   endtask

   // Full transaction; lat counts cycles from acceptance to data_ok.
   task automatic issueAndWait(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                               output logic [31:0] rd, output int lat);
      bit ok;
      bit seen = 1'b0;
      rd  = '0;
      lat = 0;
      applyStimulus(a, s, d, 0, ok);
      if (ok) begin
         while (!seen && lat < 40) begin
            @(negedge clk);
            dbus.req_valid = 1'b0;
            lat++;
            if (dbus.resp_data_ok === 1'b1) begin
               seen = 1'b1;
               rd   = dbus.resp_data;
            end
         end
         if (!seen) reportTimeout("data_ok", lat);
      end
   endtask

   task automatic busyIgnore();
      int accepts    = 0;
      int pulses     = 0;
      int first_ok   = -1;
      int second_acc = -1;
      bit drop       = 1'b0;
      @(negedge clk);
      dbus.req_valid  = 1'b1;
      dbus.req_addr   = 32'h100;
      dbus.req_strobe = 4'h0;
      dbus.req_data   = 32'h0;
      for (int c = 0; c < 12; c++) begin
         if (drop) dbus.req_valid = 1'b0;
         if (dbus.resp_data_ok === 1'b1) begin
            pulses++;
            if (first_ok < 0) first_ok = c;
         end
         if (dbus.resp_addr_ok === 1'b1 && dbus.req_valid) begin
            accepts++;
            if (accepts == 2) begin
               second_acc = c;
               drop       = 1'b1;
            end
         end
         @(negedge clk);
      end
      dbus.req_valid = 1'b0;
      checkOutput("hold_accepts", 32'(accepts), 32'd2);
      checkOutput("hold_pulses", 32'(pulses), 32'd2);
      checkOutput("hold_first_ok", 32'(first_ok), 32'd2);
      checkOutput("hold_second_acc", 32'(second_acc), 32'd3);
   endtask

   task automatic resetMidOp();
      logic [31:0] rd;
      int          lat;
      bit          ok;
      int          seen = 0;
      issueAndWait(32'h200, 4'hF, 32'h0, rd, lat);
      applyStimulus(32'h200, 4'hF, 32'hFFFF_FFFF, 0, ok);
      @(negedge clk);
      dbus.req_valid = 1'b0;
      reset          = 1'b1;
      #1;
      checkOutput("rstmid_addr_ok", 32'(dbus.resp_addr_ok), 32'd0);
      checkOutput("rstmid_data_ok", 32'(dbus.resp_data_ok), 32'd0);
      checkOutput("rstmid_busy", 32'(busy), 32'd0);
      checkOutput("rstmid_data", dbus.resp_data, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (dbus.resp_data_ok === 1'b1) seen++;
      end
      checkOutput("rstmid_no_data_ok", 32'(seen), 32'd0);
      issueAndWait(32'h200, 4'h0, 32'h0, rd, lat);
      checkOutput("rstmid_read", rd, 32'h0000_0000);
   endtask

   task automatic randomTraffic(input int count);
      logic [31:0] a;
      logic [3:0]  s;
      bit          ok;
      for (int t = 0; t < count; t++) begin
         case ($urandom_range(0, 5))
            0:       a = 32'h100;
            1:       a = 32'h104;
            2:       a = 32'h200;
            3:       a = 32'hFFC;
            default: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
         endcase
         a = (a & 32'h0000_0FFC) | ($urandom & 32'hFFFF_F003);
         s = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
         dbus.req_size = 3'($urandom_range(0, 2));
         applyStimulus(a, s, $urandom, $urandom_range(0, 3), ok);
      end
      @(negedge clk);
      dbus.req_valid = 1'b0;
      repeat (LATENCY + 4) @(negedge clk);
   endtask

   initial begin
      logic [31:0] rd;
      int          lat;
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i]   = '0;
         m_known[i] = '0;
      end
      dbus.req_valid  = 1'b0;
      dbus.req_addr   = '0;
      dbus.req_size   = 3'b010;
      dbus.req_strobe = '0;
      dbus.req_data   = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_addr_ok", 32'(dbus.resp_addr_ok), 32'd0);
      checkOutput("reset_data_ok", 32'(dbus.resp_data_ok), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_data", dbus.resp_data, 32'h0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] word write/read");
      issueAndWait(32'h100, 4'b1111, 32'h1122_3344, rd, lat);
      checkOutput("write_latency", 32'(lat), 32'd2);
      issueAndWait(32'h100, 4'b0000, 32'h0, rd, lat);
      checkOutput("read_latency", 32'(lat), 32'd2);
      checkOutput("read_word", rd, 32'h1122_3344);

      $display("[TB] byte and halfword merge");
      issueAndWait(32'h100, 4'b0010, 32'h0000_AB00, rd, lat);
      issueAndWait(32'h100, 4'b0000, 32'h0, rd, lat);
      checkOutput("byte_merge", rd, 32'h1122_AB44);
      issueAndWait(32'h100, 4'b1100, 32'hBEEF_0000, rd, lat);
      issueAndWait(32'h100, 4'b0000, 32'h0, rd, lat);
      checkOutput("half_merge", rd, 32'hBEEF_AB44);

      $display("[TB] read-before-write");
      issueAndWait(32'h100, 4'b1111, 32'hCAFE_F00D, rd, lat);
      checkOutput("rbw_old_word", rd, 32'hBEEF_AB44);
      issueAndWait(32'h100, 4'b0000, 32'h0, rd, lat);
      checkOutput("rbw_new_word", rd, 32'hCAFE_F00D);

      $display("[TB] address wrap");
      issueAndWait(32'h0000_0004, 4'b1111, 32'hA5A5_A5A5, rd, lat);
      issueAndWait(32'h0000_1004, 4'b0000, 32'h0, rd, lat);
      checkOutput("wrap_read", rd, 32'hA5A5_A5A5);

      $display("[TB] valid held while busy");
      busyIgnore();

      $display("[TB] reset mid-transaction");
      resetMidOp();

      $display("[TB] randomized traffic");
      randomTraffic(300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
